// File: rtl/uart_prog_loader.sv
// uart_prog_loader
// ----------------
// Serial program loader for the 256x16 instruction memory. An 8N1 UART byte
// stream is received on rx, assembled into 16-bit words and written into the
// memory write port at consecutive addresses starting from 0. While a load is
// in progress (or after an error) cpu_hold keeps the CPU sequencer stopped.
//
// Byte stream after start: LEN (image is LEN+1 words), then HI/LO byte pairs,
// one pair per word. With UART_LOADER_CHECKSUM_EN defined, a trailing byte
// equal to the XOR of all HI/LO bytes follows the last word.
//
// Optional feature macro: UART_LOADER_CHECKSUM_EN (undefined by default).
//
// Ports:
//   clk        clock, all logic on rising edge
//   reset      synchronous, active-high reset
//   rx         UART line, idle high, asynchronous to clk
//   start      one-cycle request to begin a load
//   mem_we     one-cycle write strobe to instruction memory
//   mem_addr   write address (word index)
//   mem_wdata  write data {HI, LO}
//   cpu_hold   high while loading, finishing or errored
//   busy       high from accepted start until done/error
//   done       one-cycle pulse after the last word is written
//   frame_err  sticky: a stop bit was sampled low during a load
//   chk_err    sticky: checksum mismatch (tied 0 without the checksum feature)
//
// Internal strobe: byte_valid is a one-cycle pulse carrying rx_byte; there is
// no back-pressure, the loader must consume the byte in that cycle.
module uart_prog_loader #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  input  logic        start,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [15:0] mem_wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        frame_err,
  output logic        chk_err
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);

  // ---------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  rx_state_t     rx_state;
  logic          rx_meta;
  logic          rx_sync;
  logic          rx_prev;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic [7:0]    rx_byte;
  logic          byte_valid;
  logic          frame_pulse;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta     <= 1'b1;
      rx_sync     <= 1'b1;
      rx_prev     <= 1'b1;
      rx_state    <= RX_IDLE;
      rx_cnt      <= '0;
      rx_bit      <= '0;
      rx_shift    <= '0;
      rx_byte     <= '0;
      byte_valid  <= 1'b0;
      frame_pulse <= 1'b0;
    end else begin
      rx_meta     <= rx;
      rx_sync     <= rx_meta;
      rx_prev     <= rx_sync;
      byte_valid  <= 1'b0;
      frame_pulse <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          // Falling edge of the synchronized line marks a candidate start bit.
          if (rx_prev && !rx_sync) begin
            rx_state <= RX_START;
            rx_cnt   <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt == CW'(HALF - 1)) begin
            rx_cnt <= '0;
            // A line already back high at mid-bit was a glitch, not a frame.
            if (rx_sync) begin
              rx_state <= RX_IDLE;
            end else begin
              rx_state <= RX_DATA;
              rx_bit   <= '0;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == CW'(CLKS_PER_BIT - 1)) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};  // LSB arrives first
            if (rx_bit == 3'd7) begin
              rx_state <= RX_STOP;
            end else begin
              rx_bit <= rx_bit + 3'd1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == CW'(CLKS_PER_BIT - 1)) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            if (rx_sync) begin
              byte_valid <= 1'b1;
              rx_byte    <= rx_shift;
            end else begin
              frame_pulse <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Loader
  // ---------------------------------------------------------------------
  typedef enum logic [2:0] {
    L_IDLE,
    L_LEN,
    L_HI,
    L_LO,
    L_CHK,
    L_DONE,
    L_ERR
  } ld_state_t;

  ld_state_t  ld_state;
  logic [7:0] len;
  logic [7:0] idx;
  logic [7:0] hi_byte;

`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0] csum;
`else
  assign chk_err = 1'b0;
`endif

  // busy mirrors "state is LEN/HI/LO/CHK"; it is set on every entry into LEN
  // and cleared on every exit from that group, so it doubles as the guard
  // for frame errors (which only matter while a load is in flight).
  always_ff @(posedge clk) begin
    if (reset) begin
      ld_state  <= L_IDLE;
      len       <= '0;
      idx       <= '0;
      hi_byte   <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_hold  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
      csum      <= '0;
      chk_err   <= 1'b0;
`endif
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      if (busy && frame_pulse) begin
        ld_state  <= L_ERR;
        frame_err <= 1'b1;
        busy      <= 1'b0;
      end else begin
        case (ld_state)
          L_IDLE: begin
            // cpu_hold is released here so it falls together with done.
            cpu_hold <= 1'b0;
            if (start) begin
              ld_state <= L_LEN;
              busy     <= 1'b1;
              cpu_hold <= 1'b1;
            end
          end
          L_LEN: begin
            if (byte_valid) begin
              len      <= rx_byte;
              idx      <= '0;
              ld_state <= L_HI;
`ifdef UART_LOADER_CHECKSUM_EN
              csum     <= '0;
`endif
            end
          end
          L_HI: begin
            if (byte_valid) begin
              hi_byte  <= rx_byte;
              ld_state <= L_LO;
`ifdef UART_LOADER_CHECKSUM_EN
              csum     <= csum ^ rx_byte;
`endif
            end
          end
          L_LO: begin
            if (byte_valid) begin
              mem_we    <= 1'b1;
              mem_addr  <= idx;
              mem_wdata <= {hi_byte, rx_byte};
`ifdef UART_LOADER_CHECKSUM_EN
              csum      <= csum ^ rx_byte;
`endif
              // Compare before incrementing so LEN=255 stops at address 255.
              if (idx == len) begin
`ifdef UART_LOADER_CHECKSUM_EN
                ld_state <= L_CHK;
`else
                ld_state <= L_DONE;
                busy     <= 1'b0;
`endif
              end else begin
                idx      <= idx + 8'd1;
                ld_state <= L_HI;
              end
            end
          end
`ifdef UART_LOADER_CHECKSUM_EN
          L_CHK: begin
            if (byte_valid) begin
              busy <= 1'b0;
              if (rx_byte == csum) begin
                ld_state <= L_DONE;
              end else begin
                chk_err  <= 1'b1;
                ld_state <= L_ERR;
              end
            end
          end
`endif
          L_DONE: begin
            done     <= 1'b1;
            ld_state <= L_IDLE;
          end
          L_ERR: begin
            if (start) begin
              frame_err <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
              chk_err   <= 1'b0;
`endif
              ld_state  <= L_LEN;
              busy      <= 1'b1;
            end
          end
          default: ld_state <= L_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
`timescale 1ns/1ps
module tb_uart_prog_loader;

  localparam int CPB = 14;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx;
  logic        start;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        frame_err;
  logic        chk_err;

  uart_prog_loader #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .start     (start),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done),
    .frame_err (frame_err),
    .chk_err   (chk_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [23:0] exp_q[$];        // {addr, data} of every write the model expects
  logic [15:0] img [256];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_we_cyc = -100;
  int          writes_seen = 0;
  int          dones_seen = 0;
  logic [7:0]  last_addr = 8'h00;
  logic        done_d = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      done_d = 1'b0;
    end else begin
      if (mem_we) begin
        check("write_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("write", {mem_addr, mem_wdata}, exp_q.pop_front());
        writes_seen++;
        last_addr   = mem_addr;
        last_we_cyc = cyc;
      end
      if (busy) check("busy_implies_hold", cpu_hold, 1'b1);
      if (done) begin
        check("done_width", done_d, 1'b0);
        check("done_hold", cpu_hold, 1'b1);
        check("done_writes_drained", exp_q.size(), 0);
`ifndef UART_LOADER_CHECKSUM_EN
        check("done_after_last_we", cyc - last_we_cyc, 1);
`endif
        if (!done_d) dones_seen++;
      end
      if (done_d && !done) check("hold_falls_with_done", cpu_hold, 1'b0);
      done_d = done;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(CPB);
    end
    rx = stop_bit;
    idle(CPB);
    rx = 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    idle(1);
    start = 1'b0;
  endtask

  task automatic gap(input int gmax);
    idle($urandom_range(0, gmax));
  endtask

  function automatic logic [7:0] xor_image(input int n);
    logic [7:0] c = 8'h00;
    for (int w = 0; w < n; w++) c = c ^ img[w][15:8] ^ img[w][7:0];
    return c;
  endfunction

  // Sends LEN and the first n_send words of img; if the whole image is sent,
  // waits (bounded) for done and checks that exactly one pulse appeared.
  task automatic load(input logic do_start, input int n_words, input int n_send,
                      input logic bad_csum, input int gmax);
    int base_dones;
    base_dones = dones_seen;
    if (do_start) begin
      pulse_start();
      check("busy_after_start", busy, 1'b1);
    end
    send_byte(8'(n_words - 1), 1'b1);
    gap(gmax);
    for (int w = 0; w < n_send; w++) begin
      send_byte(img[w][15:8], 1'b1);
      gap(gmax);
      exp_q.push_back({8'(w), img[w]});
      send_byte(img[w][7:0], 1'b1);
      gap(gmax);
    end
    if (n_send == n_words) begin
`ifdef UART_LOADER_CHECKSUM_EN
      send_byte(bad_csum ? ~xor_image(n_words) : xor_image(n_words), 1'b1);
`endif
      for (int i = 0; i < 100 && dones_seen == base_dones; i++) @(negedge clk);
      idle(4);
`ifdef UART_LOADER_CHECKSUM_EN
      check("done_count", dones_seen - base_dones, bad_csum ? 0 : 1);
`else
      check("done_count", dones_seen - base_dones, 1);
`endif
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_mem_we"},    mem_we,    1'b0);
    check({tag, "_mem_addr"},  mem_addr,  8'h00);
    check({tag, "_mem_wdata"}, mem_wdata, 16'h0000);
    check({tag, "_cpu_hold"},  cpu_hold,  1'b0);
    check({tag, "_busy"},      busy,      1'b0);
    check({tag, "_done"},      done,      1'b0);
    check({tag, "_frame_err"}, frame_err, 1'b0);
    check({tag, "_chk_err"},   chk_err,   1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base_w;
    reset = 1'b1;
    rx    = 1'b1;
    start = 1'b0;
    idle(3);
    check_reset_values("reset");
    reset = 1'b0;
    idle(5);

    // Directed image from the test plan; pin the model's checksum too.
    img[0] = 16'h1234;
    img[1] = 16'hABCD;
    check("model_xor", xor_image(2), 8'h40);
    load(1'b1, 2, 2, 1'b0, 5);
    check("t1_writes", writes_seen, 2);
    check("t1_last_addr", last_addr, 8'h01);
    check("t1_hold_released", cpu_hold, 1'b0);
    check("t1_busy_released", busy, 1'b0);

    // Frame error on the LEN byte, then restart out of ERR.
    pulse_start();
    send_byte(8'h00, 1'b0);
    idle(CPB);
    check("fe_frame_err", frame_err, 1'b1);
    check("fe_hold", cpu_hold, 1'b1);
    check("fe_busy", busy, 1'b0);
    idle(50);
    check("fe_hold_held", cpu_hold, 1'b1);
    pulse_start();
    check("fe_cleared", frame_err, 1'b0);
    check("fe_restart_busy", busy, 1'b1);

    // Short low glitch while waiting for LEN must not produce a byte.
    base_w = writes_seen;
    rx = 1'b0;
    idle(6);
    rx = 1'b1;
    idle(3 * CPB);
    check("glitch_no_write", writes_seen - base_w, 0);
    check("glitch_still_busy", busy, 1'b1);
    for (int w = 0; w < 3; w++) img[w] = 16'($urandom);
    load(1'b0, 3, 3, 1'b0, 8);
    check("glitch_load_writes", writes_seen - base_w, 3);

    // Reset in the middle of a 5-word load after 3 words.
    for (int w = 0; w < 5; w++) img[w] = 16'($urandom);
    base_w = writes_seen;
    load(1'b1, 5, 3, 1'b0, 4);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    check("rst_partial_writes", writes_seen - base_w, 3);
    reset = 1'b1;
    idle(1);
    check_reset_values("midload");
    reset = 1'b0;
    base_w = writes_seen;
    idle(300);
    check("rst_no_more_writes", writes_seen - base_w, 0);
    for (int w = 0; w < 3; w++) img[w] = 16'($urandom);
    load(1'b1, 3, 3, 1'b0, 6);
    check("reload_writes", writes_seen - base_w, 3);
    check("reload_last_addr", last_addr, 8'h02);

    // Full 256-word image: addresses must run 0..255 without wrapping.
    for (int w = 0; w < 256; w++) img[w] = 16'($urandom);
    base_w = writes_seen;
    load(1'b1, 256, 256, 1'b0, 0);
    check("full_writes", writes_seen - base_w, 256);
    check("full_last_addr", last_addr, 8'hFF);
    check("full_hold_released", cpu_hold, 1'b0);

`ifdef UART_LOADER_CHECKSUM_EN
    // Correct image, wrong checksum byte.
    for (int w = 0; w < 2; w++) img[w] = 16'($urandom);
    load(1'b1, 2, 2, 1'b1, 3);
    check("ck_chk_err", chk_err, 1'b1);
    check("ck_hold", cpu_hold, 1'b1);
    check("ck_busy", busy, 1'b0);
    idle(100);
    check("ck_err_held", chk_err, 1'b1);
    check("ck_hold_held", cpu_hold, 1'b1);
    pulse_start();
    check("ck_cleared", chk_err, 1'b0);
    check("ck_restart_busy", busy, 1'b1);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
`endif

    idle(10);
    check("queue_empty_at_end", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
